mac16_acc_sched: RTL and testbench

MAC16_ACC_SCHED -- requirements
Module: mac16_acc_sched

---
 rtl/mac16_acc_sched_pkg.sv | 18 +
 rtl/mac16_acc_sched_rr_arb2.sv | 47 ++++
 rtl/mac16_acc_sched.sv | 168 ++++++++++++++++
 tb/tb_mac16_acc_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac16_acc_sched_pkg.sv
// Shared types and defaults for the MAC16 accumulation scheduler.
// Holds the scheduler FSM encoding and the requester count.
package mac16_sched_pkg;

  localparam int N_REQ       = 2;
  localparam int MAC_LAT_DEF = 1;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_STREAM  = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4,
    S_RESULT  = 3'd5
  } state_e;

endpackage

// File: rtl/mac16_acc_sched_rr_arb2.sv
// Two-way round-robin arbiter: the priority holder wins ties, and priority
// moves to the requester that was not served whenever a result is consumed.
module rr_arb2
  import mac16_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  input  logic             served,
  output logic             gnt_valid,
  output logic             gnt
);

  logic prio_q;
  logic prio_d;

  // Next priority: hand over to the other requester after a completed result.
  always_comb begin
    prio_d = prio_q;
    if (adv) begin
      prio_d = ~served;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority register, requester 0 favoured out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Grant selection.
  always_comb begin
    gnt_valid = |req;
    if (req[prio_q]) begin
      gnt = prio_q;
    end else begin
      gnt = ~prio_q;
    end
  end

endmodule

// File: rtl/mac16_acc_sched.sv
// Schedules two requesters' operand vectors onto one MAC16 accumulator:
// clear, stream beats, drain the MAC pipeline, capture and hand back the sum.
module mac16_acc_sched
  import mac16_sched_pkg::*;
#(
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ_VALID,
  output logic [N_REQ-1:0] REQ_READY,
  input  logic [31:0]      REQ_A,
  input  logic [31:0]      REQ_B,
  input  logic [N_REQ-1:0] REQ_SUB,
  input  logic [N_REQ-1:0] REQ_LAST,
  output logic [15:0]      MAC_A,
  output logic [15:0]      MAC_B,
  output logic             MAC_CE,
  output logic             MAC_ORST,
  output logic             MAC_ADDSUB,
  input  logic [31:0]      MAC_O,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [31:0]      RES_DATA,
  output logic             RES_ID,
  output logic [CNT_W-1:0] RES_CNT
);

  // DRAIN runs MAC_LAT-1 cycles; the counter is loaded with one less than that.
  localparam logic [1:0]       DRAIN_LOAD = (MAC_LAT > 1) ? 2'(MAC_LAT - 2) : 2'd0;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       drain_q, drain_d;
  logic [31:0]      res_data_q, res_data_d;

  logic             arb_valid_s;
  logic             arb_gnt_s;
  logic             arb_adv_s;
  logic [15:0]      gnt_a_s;
  logic [15:0]      gnt_b_s;
  logic [N_REQ-1:0] ready_s;
  logic [15:0]      mac_a_s;
  logic [15:0]      mac_b_s;
  logic             mac_ce_s;
  logic             mac_addsub_s;

  rr_arb2 u_arb (
    .clk       (CLK),
    .rst       (RST),
    .req       (REQ_VALID),
    .adv       (arb_adv_s),
    .served    (gnt_q),
    .gnt_valid (arb_valid_s),
    .gnt       (arb_gnt_s)
  );

  assign gnt_a_s = gnt_q ? REQ_A[31:16] : REQ_A[15:0];
  assign gnt_b_s = gnt_q ? REQ_B[31:16] : REQ_B[15:0];

  // Next-state and MAC drive; MAC inputs are zero unless a beat or drain is live.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    res_data_d   = res_data_q;
    arb_adv_s    = 1'b0;
    ready_s      = {N_REQ{1'b0}};
    mac_a_s      = 16'd0;
    mac_b_s      = 16'd0;
    mac_ce_s     = 1'b0;
    mac_addsub_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_valid_s) begin
          gnt_d   = arb_gnt_s;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        ready_s[gnt_q] = 1'b1;
        if (REQ_VALID[gnt_q]) begin
          mac_a_s      = gnt_a_s;
          mac_b_s      = gnt_b_s;
          mac_ce_s     = 1'b1;
          mac_addsub_s = REQ_SUB[gnt_q];
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
          if (REQ_LAST[gnt_q]) begin
            drain_d = DRAIN_LOAD;
            state_d = (MAC_LAT > 1) ? S_DRAIN : S_CAPTURE;
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        // Clock zero products through so the last real beat reaches the accumulator.
        mac_ce_s = 1'b1;
        if (drain_q == 2'd0) begin
          state_d = S_CAPTURE;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      S_CAPTURE: begin
        res_data_d = MAC_O;
        state_d    = S_RESULT;
      end
      S_RESULT: begin
        if (RES_READY) begin
          arb_adv_s = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scheduler state, grant, beat count and captured result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      drain_q    <= 2'd0;
      res_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      res_data_q <= res_data_d;
    end
  end

  assign REQ_READY  = ready_s;
  assign MAC_A      = mac_a_s;
  assign MAC_B      = mac_b_s;
  assign MAC_CE     = mac_ce_s;
  assign MAC_ADDSUB = mac_addsub_s;
  assign MAC_ORST   = RST | (state_q == S_CLR);
  assign RES_VALID  = (state_q == S_RESULT);
  assign RES_DATA   = res_data_q;
  assign RES_ID     = gnt_q;
  assign RES_CNT    = cnt_q;

endmodule

// File: tb/tb_mac16_acc_sched.sv
// Directed bench for mac16_acc_sched: two instances (MAC_LAT 1 and 3), each
// wired to a small behavioural MAC16 accumulator model.
module tb_mac16_acc_sched;

  logic        clk, rst;
  int          n_chk, n_fail;

  logic [1:0]  req_valid, req_ready, req_sub, req_last;
  logic [31:0] req_a, req_b, mac_o, res_data;
  logic [15:0] mac_a, mac_b, res_cnt;
  logic        mac_ce, mac_orst, mac_addsub, res_valid, res_ready, res_id;
  logic [31:0] prod1;

  logic [1:0]  req_valid3, req_ready3, req_sub3, req_last3;
  logic [31:0] req_a3, req_b3, mac_o3, res_data3;
  logic [15:0] mac_a3, mac_b3, res_cnt3;
  logic        mac_ce3, mac_orst3, mac_addsub3, res_valid3, res_ready3, res_id3;
  logic [31:0] prod3, p3_0, p3_1;
  logic        s3_0, s3_1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mac16_acc_sched #(.MAC_LAT(1), .CNT_W(16)) u_dut1 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_A(req_a), .REQ_B(req_b), .REQ_SUB(req_sub), .REQ_LAST(req_last),
    .MAC_A(mac_a), .MAC_B(mac_b), .MAC_CE(mac_ce), .MAC_ORST(mac_orst),
    .MAC_ADDSUB(mac_addsub), .MAC_O(mac_o), .RES_VALID(res_valid),
    .RES_READY(res_ready), .RES_DATA(res_data), .RES_ID(res_id), .RES_CNT(res_cnt)
  );

  mac16_acc_sched #(.MAC_LAT(3), .CNT_W(16)) u_dut3 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid3), .REQ_READY(req_ready3),
    .REQ_A(req_a3), .REQ_B(req_b3), .REQ_SUB(req_sub3), .REQ_LAST(req_last3),
    .MAC_A(mac_a3), .MAC_B(mac_b3), .MAC_CE(mac_ce3), .MAC_ORST(mac_orst3),
    .MAC_ADDSUB(mac_addsub3), .MAC_O(mac_o3), .RES_VALID(res_valid3),
    .RES_READY(res_ready3), .RES_DATA(res_data3), .RES_ID(res_id3), .RES_CNT(res_cnt3)
  );

  // MAC16 model, one-cycle latency: registered accumulator
  assign prod1 = {16'd0, mac_a} * {16'd0, mac_b};
  always_ff @(posedge clk) begin
    if (mac_orst) mac_o <= 32'd0;
    else if (mac_ce) mac_o <= mac_addsub ? (mac_o - prod1) : (mac_o + prod1);
  end

  // MAC16 model, three-cycle latency: two product stages then accumulator
  assign prod3 = {16'd0, mac_a3} * {16'd0, mac_b3};
  always_ff @(posedge clk) begin
    if (mac_orst3) begin
      p3_0 <= 32'd0; p3_1 <= 32'd0; s3_0 <= 1'b0; s3_1 <= 1'b0; mac_o3 <= 32'd0;
    end else if (mac_ce3) begin
      p3_0 <= prod3; s3_0 <= mac_addsub3;
      p3_1 <= p3_0;  s3_1 <= s3_0;
      mac_o3 <= s3_1 ? (mac_o3 - p3_1) : (mac_o3 + p3_1);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %0h expected 0", res_valid); end
    n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %0h expected 0", req_ready); end
    n_chk++; if (res_data !== 32'd0) begin n_fail++; $display("FAIL reset_res_data: got %0h expected 0", res_data); end
    n_chk++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL reset_res_id: got %0h expected 0", res_id); end
    n_chk++; if (res_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_res_cnt: got %0h expected 0", res_cnt); end
    n_chk++; if ({mac_ce, mac_addsub} !== 2'b00) begin n_fail++; $display("FAIL reset_mac_ctl: got %0h expected 0", {mac_ce, mac_addsub}); end
    n_chk++; if ({mac_a, mac_b} !== 32'd0) begin n_fail++; $display("FAIL reset_mac_ab: got %0h expected 0", {mac_a, mac_b}); end
    n_chk++; if ({mac_orst, mac_orst3} !== 2'b11) begin n_fail++; $display("FAIL reset_mac_orst: got %0h expected 3", {mac_orst, mac_orst3}); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (mac_orst !== 1'b0) begin n_fail++; $display("FAIL idle_mac_orst: got %0h expected 0", mac_orst); end
  endtask

  task automatic test_basic();
    req_valid = 2'b01; req_a = 32'd3; req_b = 32'd4; req_sub = 2'b00; req_last = 2'b00;
    @(negedge clk);
    n_chk++; if ({mac_orst, mac_ce, req_ready} !== 4'b1000) begin n_fail++; $display("FAIL basic_clr: got orst/ce/ready %0h expected 8", {mac_orst, mac_ce, req_ready}); end
    @(negedge clk);
    n_chk++; if ({mac_orst, mac_ce, req_ready} !== 4'b0101) begin n_fail++; $display("FAIL basic_stream1: got orst/ce/ready %0h expected 5", {mac_orst, mac_ce, req_ready}); end
    n_chk++; if ({mac_a, mac_b} !== {16'd3, 16'd4}) begin n_fail++; $display("FAIL basic_ab1: got %0h expected 30004", {mac_a, mac_b}); end
    @(negedge clk);
    req_a = 32'd5; req_b = 32'd6; req_last = 2'b01;
    #1;
    n_chk++; if ({mac_a, mac_b} !== {16'd5, 16'd6}) begin n_fail++; $display("FAIL basic_ab2: got %0h expected 50006", {mac_a, mac_b}); end
    @(negedge clk);
    req_valid = 2'b00; req_last = 2'b00;
    n_chk++; if ({res_valid, mac_ce, req_ready} !== 4'b0000) begin n_fail++; $display("FAIL basic_capture: got %0h expected 0", {res_valid, mac_ce, req_ready}); end
    @(negedge clk);
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_res_valid: got %0h expected 1", res_valid); end
    n_chk++; if (res_data !== 32'd42) begin n_fail++; $display("FAIL basic_res_data: got %0d expected 42", res_data); end
    n_chk++; if (res_id !== 1'b0) begin n_fail++; $display("FAIL basic_res_id: got %0d expected 0", res_id); end
    n_chk++; if (res_cnt !== 16'd2) begin n_fail++; $display("FAIL basic_res_cnt: got %0d expected 2", res_cnt); end
    @(negedge clk);
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_res_drop: got %0h expected 0", res_valid); end
  endtask

  task automatic test_round_robin();
    int nres;
    int orst_cnt;
    logic exp_id;
    rst = 1'b1;
    req_valid = 2'b11; req_last = 2'b11; req_sub = 2'b00;
    req_a = {16'd4, 16'd2}; req_b = {16'd5, 16'd3};
    @(negedge clk);
    rst = 1'b0;
    nres = 0; orst_cnt = 0;
    for (int i = 0; i < 40 && nres < 4; i++) begin
      @(negedge clk);
      if (mac_orst) orst_cnt++;
      if (res_valid) begin
        exp_id = nres[0];
        n_chk++; if (res_id !== exp_id) begin n_fail++; $display("FAIL rr_order[%0d]: got id %0d expected %0d", nres, res_id, exp_id); end
        n_chk++; if (res_data !== (exp_id ? 32'd20 : 32'd6)) begin n_fail++; $display("FAIL rr_data[%0d]: got %0d expected %0d", nres, res_data, exp_id ? 20 : 6); end
        n_chk++; if (orst_cnt != 1) begin n_fail++; $display("FAIL rr_clr_len[%0d]: got %0d expected 1", nres, orst_cnt); end
        orst_cnt = 0;
        nres++;
      end
    end
    req_valid = 2'b00; req_last = 2'b00;
    n_chk++; if (nres != 4) begin n_fail++; $display("FAIL rr_timeout: got %0d results expected 4", nres); end
    @(negedge clk);
  endtask

  task automatic test_sub();
    req_valid = 2'b10; req_a = {16'd10, 16'd0}; req_b = {16'd10, 16'd0}; req_sub = 2'b00; req_last = 2'b00;
    @(negedge clk);
    n_chk++; if (mac_orst !== 1'b1) begin n_fail++; $display("FAIL sub_clr: got %0h expected 1", mac_orst); end
    @(negedge clk);
    n_chk++; if ({req_ready, mac_addsub, mac_a} !== {2'b10, 1'b0, 16'd10}) begin n_fail++; $display("FAIL sub_beat1: got %0h expected %0h", {req_ready, mac_addsub, mac_a}, {2'b10, 1'b0, 16'd10}); end
    @(negedge clk);
    req_a = {16'd2, 16'd0}; req_b = {16'd3, 16'd0}; req_sub = 2'b10; req_last = 2'b10;
    #1;
    n_chk++; if ({mac_addsub, mac_a, mac_b} !== {1'b1, 16'd2, 16'd3}) begin n_fail++; $display("FAIL sub_beat2: got %0h expected %0h", {mac_addsub, mac_a, mac_b}, {1'b1, 16'd2, 16'd3}); end
    @(negedge clk);
    req_valid = 2'b00; req_sub = 2'b00; req_last = 2'b00;
    @(negedge clk);
    n_chk++; if ({res_valid, res_id} !== 2'b11) begin n_fail++; $display("FAIL sub_res_id: got valid/id %0h expected 3", {res_valid, res_id}); end
    n_chk++; if (res_data !== 32'd94) begin n_fail++; $display("FAIL sub_res_data: got %0d expected 94", res_data); end
    @(negedge clk);
  endtask

  task automatic test_lat3();
    req_valid3 = 2'b01; req_a3 = 32'h0000_FFFF; req_b3 = 32'h0000_FFFF; req_sub3 = 2'b00; req_last3 = 2'b01;
    @(negedge clk);
    req_valid3 = 2'b00;
    n_chk++; if (mac_orst3 !== 1'b1) begin n_fail++; $display("FAIL lat3_clr: got %0h expected 1", mac_orst3); end
    @(negedge clk);
    n_chk++; if ({req_ready3, mac_ce3, mac_a3, mac_b3} !== {2'b01, 1'b0, 32'd0}) begin n_fail++; $display("FAIL lat3_gap: got %0h expected %0h", {req_ready3, mac_ce3, mac_a3, mac_b3}, {2'b01, 1'b0, 32'd0}); end
    req_valid3 = 2'b01;
    #1;
    n_chk++; if ({mac_ce3, mac_a3} !== {1'b1, 16'hFFFF}) begin n_fail++; $display("FAIL lat3_beat: got %0h expected 1ffff", {mac_ce3, mac_a3}); end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      req_valid3 = 2'b00;
      n_chk++; if ({mac_ce3, mac_addsub3, mac_a3, mac_b3, req_ready3, res_valid3} !== {1'b1, 1'b0, 32'd0, 2'b00, 1'b0}) begin
        n_fail++; $display("FAIL lat3_drain[%0d]: got ce %0h addsub %0h ab %0h ready %0h rv %0h", d, mac_ce3, mac_addsub3, {mac_a3, mac_b3}, req_ready3, res_valid3);
      end
    end
    @(negedge clk);
    n_chk++; if ({mac_ce3, res_valid3} !== 2'b00) begin n_fail++; $display("FAIL lat3_capture: got %0h expected 0", {mac_ce3, res_valid3}); end
    @(negedge clk);
    n_chk++; if (res_valid3 !== 1'b1) begin n_fail++; $display("FAIL lat3_res_valid: got %0h expected 1", res_valid3); end
    n_chk++; if (res_data3 !== 32'hFFFE_0001) begin n_fail++; $display("FAIL lat3_res_data: got %0h expected fffe0001", res_data3); end
    n_chk++; if ({res_id3, res_cnt3} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL lat3_id_cnt: got %0h expected 1", {res_id3, res_cnt3}); end
    @(negedge clk);
    req_last3 = 2'b00;
  endtask

  task automatic test_stall();
    res_ready = 1'b0;
    req_valid = 2'b01; req_a = {16'd1, 16'd7}; req_b = {16'd1, 16'd8}; req_sub = 2'b00; req_last = 2'b11;
    repeat (3) @(negedge clk);
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++; if ({res_valid, res_id, res_cnt, res_data} !== {1'b1, 1'b0, 16'd1, 32'd56}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got rv %0h id %0h cnt %0d data %0d expected 1 0 1 56", k, res_valid, res_id, res_cnt, res_data);
      end
      n_chk++; if ({req_ready, mac_orst, mac_ce} !== 4'b0000) begin n_fail++; $display("FAIL stall_quiet[%0d]: got %0h expected 0", k, {req_ready, mac_orst, mac_ce}); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_chk++; if ({res_valid, mac_orst} !== 2'b00) begin n_fail++; $display("FAIL stall_release: got %0h expected 0", {res_valid, mac_orst}); end
    @(negedge clk);
    n_chk++; if ({mac_orst, res_id, res_cnt} !== {1'b1, 1'b1, 16'd0}) begin n_fail++; $display("FAIL stall_regrant: got orst %0h id %0h cnt %0d expected 1 1 0", mac_orst, res_id, res_cnt); end
    @(negedge clk);
    n_chk++; if ({req_ready, mac_ce, mac_a} !== {2'b10, 1'b1, 16'd1}) begin n_fail++; $display("FAIL stall_stream: got %0h expected %0h", {req_ready, mac_ce, mac_a}, {2'b10, 1'b1, 16'd1}); end
    @(negedge clk);
    req_valid = 2'b00; req_last = 2'b00;
    @(negedge clk);
    n_chk++; if ({res_valid, res_id, res_cnt, res_data} !== {1'b1, 1'b1, 16'd1, 32'd1}) begin
      n_fail++; $display("FAIL stall_second: got rv %0h id %0h cnt %0d data %0d expected 1 1 1 1", res_valid, res_id, res_cnt, res_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_a = {16'd9, 16'd3}; req_b = {16'd9, 16'd3}; req_last = 2'b01;
    repeat (3) @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    n_chk++; if ({res_valid, res_data} !== {1'b1, 32'd9}) begin n_fail++; $display("FAIL rmid_pre: got rv %0h data %0d expected 1 9", res_valid, res_data); end
    @(negedge clk);
    req_valid = 2'b10; req_last = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1; req_valid = 2'b11; req_last = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++; if ({req_ready, res_valid, res_id, res_cnt, res_data} !== 52'd0) begin
        n_fail++; $display("FAIL rmid_outs[%0d]: got ready %0h rv %0h id %0h cnt %0d data %0h expected 0", k, req_ready, res_valid, res_id, res_cnt, res_data);
      end
      n_chk++; if ({mac_orst, mac_ce, mac_addsub, mac_a, mac_b} !== {1'b1, 34'd0}) begin
        n_fail++; $display("FAIL rmid_mac[%0d]: got orst %0h ce %0h addsub %0h ab %0h expected 1 0 0 0", k, mac_orst, mac_ce, mac_addsub, {mac_a, mac_b});
      end
      @(negedge clk);
    end
    req_a = {16'd9, 16'd2}; req_b = {16'd9, 16'd2};
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({mac_orst, res_id} !== 2'b10) begin n_fail++; $display("FAIL rmid_regrant: got orst/id %0h expected 2", {mac_orst, res_id}); end
    @(negedge clk);
    n_chk++; if ({req_ready, mac_a} !== {2'b01, 16'd2}) begin n_fail++; $display("FAIL rmid_stream: got %0h expected %0h", {req_ready, mac_a}, {2'b01, 16'd2}); end
    @(negedge clk);
    req_valid = 2'b00; req_last = 2'b00;
    @(negedge clk);
    n_chk++; if ({res_valid, res_id, res_cnt, res_data} !== {1'b1, 1'b0, 16'd1, 32'd4}) begin
      n_fail++; $display("FAIL rmid_result: got rv %0h id %0h cnt %0d data %0d expected 1 0 1 4", res_valid, res_id, res_cnt, res_data);
    end
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    req_valid = 2'b00; req_a = 32'd0; req_b = 32'd0; req_sub = 2'b00; req_last = 2'b00; res_ready = 1'b1;
    req_valid3 = 2'b00; req_a3 = 32'd0; req_b3 = 32'd0; req_sub3 = 2'b00; req_last3 = 2'b00; res_ready3 = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_sub();
    test_lat3();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
